// File: rtl/det_pkg.sv
// Shared definitions for the Bareiss determinant engine: default widths, FSM state encoding, index-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_N  = 4;
  localparam int DEF_ACC_W  = 40;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PIVOT  = 3'd1,
    SWAP   = 3'd2,
    UPDATE = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Bits needed to address a row/column 0..max_n-1 (never less than 1).
  function automatic int idx_w(input int max_n);
    return (max_n <= 2) ? 1 : $clog2(max_n);
  endfunction

endpackage

// File: rtl/det_bareiss_pe.sv
// Bareiss element update z = (p*x - q*y) / d, exact signed division.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: p,x,q,y,d - signed ACC_W operands (d never zero in use); z - signed ACC_W result.
module det_bareiss_pe #(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] p,
  input  logic signed [ACC_W-1:0] x,
  input  logic signed [ACC_W-1:0] q,
  input  logic signed [ACC_W-1:0] y,
  input  logic signed [ACC_W-1:0] d,
  output logic signed [ACC_W-1:0] z
);

  localparam int PW = 2 * ACC_W;

  logic signed [PW-1:0] num;

  // Products are formed at double width so the cross terms never wrap before the divide.
  assign num = (PW'(p) * PW'(x)) - (PW'(q) * PW'(y));
  // Bareiss guarantees the quotient is exact and fits back into ACC_W.
  assign z   = ACC_W'(num / PW'(d));

endmodule

// File: rtl/det_nxn_bareiss.sv
// Run-time sized (1..MAX_N) signed determinant via fraction-free Bareiss elimination with row pivoting.
// Latency: 1 + sum_k(probes + swap + (n-1-k)^2 + 1) edges from accepted start to done; one element per cycle.
// Backpressure: none; start is ignored while busy, result held until the next run completes.
// Ports: clk/rst_n; start+size+mat_in (row-major, DATA_W per element) in; busy, done pulse, err (valid with done), result out.
module det_nxn_bareiss
  import det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_N  = DEF_MAX_N,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_N+1)-1:0]      size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   mat_in,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic signed [ACC_W-1:0]         result
);

  localparam int SZ_W = $clog2(MAX_N + 1);
  localparam int IX_W = idx_w(MAX_N);

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] a [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] prev;
  logic signed [ACC_W-1:0] upd;
  logic signed [ACC_W-1:0] fin_val;
  logic [IX_W-1:0] k, r, i, j, nm1;
  logic neg, bad, sing;
  logic size_bad, piv_nz, last_upd, last_k;

  assign size_bad = (size == '0) || (size > SZ_W'(MAX_N));
  assign piv_nz   = (a[r][k] != '0);
  assign last_upd = (i == nm1) && (j == nm1);
  assign last_k   = (k == nm1 - IX_W'(1));
  assign fin_val  = neg ? -a[nm1][nm1] : a[nm1][nm1];

  det_bareiss_pe #(.ACC_W(ACC_W)) u_pe (
    .p (a[k][k]),
    .x (a[i][j]),
    .q (a[i][k]),
    .y (a[k][j]),
    .d (prev),
    .z (upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (size_bad || size == SZ_W'(1)) ? FINISH : PIVOT;
      PIVOT: begin
        if (piv_nz)         state_nxt = (r == k) ? UPDATE : SWAP;
        else if (r == nm1)  state_nxt = FINISH;
      end
      SWAP:   state_nxt = UPDATE;
      UPDATE: if (last_upd) state_nxt = NEXT;
      NEXT:   state_nxt = last_k ? FINISH : PIVOT;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      k      <= '0;
      r      <= '0;
      i      <= '0;
      j      <= '0;
      nm1    <= '0;
      neg    <= 1'b0;
      bad    <= 1'b0;
      sing   <= 1'b0;
      prev   <= ACC_W'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          k    <= '0;
          r    <= '0;
          neg  <= 1'b0;
          sing <= 1'b0;
          bad  <= size_bad;
          prev <= ACC_W'(1);
          nm1  <= IX_W'(size - SZ_W'(1));
        end
        PIVOT: begin
          if (piv_nz) begin
            i <= k + IX_W'(1);
            j <= k + IX_W'(1);
          end else if (r == nm1) begin
            sing <= 1'b1;
          end else begin
            r <= r + IX_W'(1);
          end
        end
        SWAP: neg <= ~neg;
        UPDATE: begin
          // Row-major walk over the trailing (n-1-k)^2 block.
          if (j == nm1) begin
            j <= k + IX_W'(1);
            i <= i + IX_W'(1);
          end else begin
            j <= j + IX_W'(1);
          end
        end
        NEXT: begin
          prev <= a[k][k];
          k    <= k + IX_W'(1);
          r    <= k + IX_W'(1);
        end
        FINISH: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          err    <= bad;
          result <= (bad || sing) ? '0 : fin_val;
        end
        default: ;
      endcase
    end
  end

  // Working matrix: pure datapath, no reset needed since every run reloads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int rr = 0; rr < MAX_N; rr++)
        for (int cc = 0; cc < MAX_N; cc++)
          a[rr][cc] <= ACC_W'($signed(mat_in[(rr*MAX_N+cc)*DATA_W +: DATA_W]));
    end else if (state == SWAP) begin
      for (int cc = 0; cc < MAX_N; cc++) begin
        a[k][cc] <= a[r][cc];
        a[r][cc] <= a[k][cc];
      end
    end else if (state == UPDATE) begin
      // Column k below the pivot is never written, so q stays valid all pass.
      a[i][j] <= upd;
    end
  end

endmodule

// File: tb/tb_det_nxn_bareiss.sv
// Directed and golden-model stimulus for det_nxn_bareiss.
// Latency: measured in edges from the start-sampling edge to done.
// Backpressure: n/a.
module tb_det_nxn_bareiss;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 4;
  localparam int ACC_W  = 40;
  localparam int SZ_W   = 3;
  localparam int MW     = MAX_N * MAX_N * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [SZ_W-1:0] size = '0;
  logic [MW-1:0] mat_in = '0;
  logic busy, done, err;
  logic signed [ACC_W-1:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  det_nxn_bareiss #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .mat_in(mat_in),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [MW-1:0] pack(input int m[16]);
    logic [MW-1:0] v;
    logic [31:0] e;
    v = '0;
    for (int idx = 0; idx < 16; idx++) begin
      e = m[idx];
      v[idx*DATA_W +: DATA_W] = e[DATA_W-1:0];
    end
    return v;
  endfunction

  function automatic longint det3m(input int m[16], input int r0, input int r1, input int r2,
                                   input int c0, input int c1, input int c2);
    longint a, b, c, d, e, f, g, h, q;
    a = m[r0*4+c0]; b = m[r0*4+c1]; c = m[r0*4+c2];
    d = m[r1*4+c0]; e = m[r1*4+c1]; f = m[r1*4+c2];
    g = m[r2*4+c0]; h = m[r2*4+c1]; q = m[r2*4+c2];
    return a*(e*q - f*h) - b*(d*q - f*g) + c*(d*h - e*g);
  endfunction

  function automatic longint det4g(input int m[16]);
    longint s;
    int c0, c1, c2;
    s = 0;
    for (int c = 0; c < 4; c++) begin
      c0 = (c == 0) ? 1 : 0;
      c1 = (c <= 1) ? 2 : 1;
      c2 = (c <= 2) ? 3 : 2;
      if (c % 2 == 0) s = s + longint'(m[c]) * det3m(m, 1, 2, 3, c0, c1, c2);
      else            s = s - longint'(m[c]) * det3m(m, 1, 2, 3, c0, c1, c2);
    end
    return s;
  endfunction

  // Drives one run and reports what the DUT produced; comparisons are made by the callers.
  task automatic run(input int n, input logic [MW-1:0] m,
                     output logic signed [ACC_W-1:0] res, output logic e,
                     output int lat, output logic busy_ok, output logic tmo);
    @(negedge clk);
    size = SZ_W'(n); mat_in = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; busy_ok = busy; tmo = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin tmo = 1'b0; break; end
      if (!busy) busy_ok = 1'b0;
    end
    res = result; e = err;
  endtask

  logic signed [ACC_W-1:0] res;
  logic e, bok, tmo;
  int lat;
  int m [16];

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_diag();
    m = '{2,0,0,0, 0,3,0,0, 0,0,4,0, 0,0,0,5};
    run(4, pack(m), res, e, lat, bok, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL diag_timeout got=%b exp=0", tmo); end
    checks++; if (res !== ACC_W'(120)) begin failures++; $display("FAIL diag_result got=%0d exp=120", res); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL diag_err got=%b exp=0", e); end
    checks++; if (lat != 21) begin failures++; $display("FAIL diag_latency got=%0d exp=21", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL diag_busy got=%b exp=1", bok); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL diag_done_pulse got=%b exp=0", done); end
    checks++; if (result !== ACC_W'(120)) begin failures++; $display("FAIL diag_hold got=%0d exp=120", result); end
  endtask

  task automatic test_swap();
    m = '{0,1,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0};
    run(2, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(-1)) begin failures++; $display("FAIL swap_result got=%0d exp=-1", res); end
    checks++; if (lat != 6) begin failures++; $display("FAIL swap_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_3x3();
    m = '{1,2,3,0, 4,5,6,0, 7,8,10,0, 0,0,0,0};
    run(3, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(-3)) begin failures++; $display("FAIL m3a_result got=%0d exp=-3", res); end
    checks++; if (lat != 10) begin failures++; $display("FAIL m3a_latency got=%0d exp=10", lat); end
    m = '{1,2,3,0, 4,5,6,0, 7,8,9,0, 0,0,0,0};
    run(3, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(0)) begin failures++; $display("FAIL m3b_result got=%0d exp=0", res); end
    checks++; if (lat != 10) begin failures++; $display("FAIL m3b_latency got=%0d exp=10", lat); end
  endtask

  task automatic test_singular();
    m = '{0,1,2,3, 0,4,5,6, 0,7,8,9, 0,1,1,1};
    run(4, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(0)) begin failures++; $display("FAIL sing_result got=%0d exp=0", res); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sing_err got=%b exp=0", e); end
    checks++; if (lat != 5) begin failures++; $display("FAIL sing_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_neg_diag();
    m = '{-128,0,0,0, 0,-128,0,0, 0,0,-128,0, 0,0,0,-128};
    run(4, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(268435456)) begin failures++; $display("FAIL negdiag_result got=%0d exp=268435456", res); end
    checks++; if (lat != 21) begin failures++; $display("FAIL negdiag_latency got=%0d exp=21", lat); end
  endtask

  task automatic test_golden();
    longint g;
    // a[1][1] becomes 0 after the first pass, forcing a swap with row 2 at k=1.
    m = '{1,2,3,4, 2,4,5,6, 3,1,2,5, 4,3,1,2};
    g = det4g(m);
    run(4, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(g)) begin failures++; $display("FAIL pivk1_result got=%0d exp=%0d", res, g); end
    checks++; if (lat != 23) begin failures++; $display("FAIL pivk1_latency got=%0d exp=23", lat); end
    for (int t = 0; t < 8; t++) begin
      for (int idx = 0; idx < 16; idx++) m[idx] = int'($urandom_range(255, 0)) - 128;
      g = (t < 4) ? det4g(m) : det3m(m, 0, 1, 2, 0, 1, 2);
      run((t < 4) ? 4 : 3, pack(m), res, e, lat, bok, tmo);
      checks++;
      if (res !== ACC_W'(g) || e !== 1'b0 || tmo !== 1'b0) begin
        failures++; $display("FAIL rand%0d got=%0d err=%b tmo=%b exp=%0d err=0", t, res, e, tmo, g);
      end
    end
  endtask

  task automatic test_size_edge();
    m = '{-7,5,5,5, 5,5,5,5, 5,5,5,5, 5,5,5,5};
    run(1, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(-7)) begin failures++; $display("FAIL n1_result got=%0d exp=-7", res); end
    checks++; if (lat != 1) begin failures++; $display("FAIL n1_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL n1_err got=%b exp=0", e); end
    run(0, pack(m), res, e, lat, bok, tmo);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL n0_err got=%b exp=1", e); end
    checks++; if (res !== ACC_W'(0)) begin failures++; $display("FAIL n0_result got=%0d exp=0", res); end
    checks++; if (lat != 1) begin failures++; $display("FAIL n0_latency got=%0d exp=1", lat); end
    run(MAX_N + 1, pack(m), res, e, lat, bok, tmo);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL nbig_err got=%b exp=1", e); end
    checks++; if (res !== ACC_W'(0)) begin failures++; $display("FAIL nbig_result got=%0d exp=0", res); end
  endtask

  task automatic test_busy_start();
    int other [16];
    m = '{2,0,0,0, 0,3,0,0, 0,0,4,0, 0,0,0,5};
    other = '{9,9,9,9, 1,2,3,4, 5,6,7,8, 1,1,1,2};
    @(negedge clk);
    size = 3'd4; mat_in = pack(m); start = 1'b1;
    @(posedge clk); #1;
    // Hold start high with different operands for the whole run.
    size = 3'd2; mat_in = pack(other);
    lat = 0; tmo = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin tmo = 1'b0; break; end
    end
    start = 1'b0;
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL busystart_timeout got=%b exp=0", tmo); end
    checks++; if (result !== ACC_W'(120)) begin failures++; $display("FAIL busystart_result got=%0d exp=120", result); end
    checks++; if (lat != 21) begin failures++; $display("FAIL busystart_latency got=%0d exp=21", lat); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busystart_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    m = '{2,0,0,0, 0,3,0,0, 0,0,4,0, 0,0,0,5};
    @(negedge clk);
    size = 3'd4; mat_in = pack(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL rstmid_result got=%0d exp=0", result); end
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rstmid_nodone got=%b exp=0", saw_done); end
    m = '{1,2,3,0, 4,5,6,0, 7,8,10,0, 0,0,0,0};
    run(3, pack(m), res, e, lat, bok, tmo);
    checks++; if (res !== ACC_W'(-3)) begin failures++; $display("FAIL rstmid_rerun got=%0d exp=-3", res); end
    checks++; if (lat != 10) begin failures++; $display("FAIL rstmid_latency got=%0d exp=10", lat); end
  endtask

  initial begin
    test_reset();
    test_diag();
    test_swap();
    test_3x3();
    test_singular();
    test_neg_diag();
    test_golden();
    test_size_edge();
    test_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
